gpu_rect_sequencer: RTL and testbench

//  Upstream command stage for the GPU register window. Accepts one rectangle-fill command
//  (x, y, w, h, colour) per valid/ready handshake and breaks it into one horizontal span per row.
//  For each span it drives the GPU write/read register port and polls BUSY until the span is done.

---
 rtl/gpu_rect_sequencer_pkg.sv | 35 +++
 rtl/gpu_rect_clip.sv | 23 ++
 rtl/gpu_rect_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_gpu_rect_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_rect_sequencer_pkg.sv
// Shared definitions for the rectangle-fill sequencer: GPU register map,
// display bounds and FSM state encoding.
package gpu_rect_sequencer_pkg;

    localparam int unsigned H_DISP = 800;
    localparam int unsigned V_DISP = 480;

    localparam logic [7:0] REG_X_POS  = 8'd0;
    localparam logic [7:0] REG_Y_POS  = 8'd1;
    localparam logic [7:0] REG_PIXEL  = 8'd2;
    localparam logic [7:0] REG_LEN    = 8'd3;
    localparam logic [7:0] REG_ENABLE = 8'd4;
    localparam logic [7:0] REG_BUSY   = 8'd7;

    // BUSY reads lag the ENABLE write, so the first samples in WAIT_HI are stale
    localparam logic [15:0] BUSY_IGNORE = 16'd2;

    typedef enum logic [3:0] {
        IDLE,
        WR_X,
        WR_Y,
        WR_PIX,
        WR_LEN,
        WR_EN,
        WAIT_HI,
        WAIT_LO,
        WR_DIS,
        FIN
    } rectState_t;

    function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/gpu_rect_clip.sv
// Combinational clip of a rectangle against the visible display area.
module gpu_rect_clip #(
    parameter int unsigned H_DISP = gpu_rect_sequencer_pkg::H_DISP,
    parameter int unsigned V_DISP = gpu_rect_sequencer_pkg::V_DISP
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] w,
    input  logic [15:0] h,
    output logic [15:0] wClip,
    output logic [15:0] hClip,
    output logic        outside
);
    import gpu_rect_sequencer_pkg::min16;

    localparam logic [15:0] H_LIM = 16'(H_DISP);
    localparam logic [15:0] V_LIM = 16'(V_DISP);

    assign outside = (x >= H_LIM) || (y >= V_LIM);
    assign wClip   = outside ? 16'd0 : min16(w, H_LIM - x);
    assign hClip   = outside ? 16'd0 : min16(h, V_LIM - y);

endmodule

// File: rtl/gpu_rect_sequencer.sv
// Breaks a rectangle-fill command into per-row GPU span writes and polls BUSY.
// Optional clipping to the display area is enabled by defining RECT_CLIP_EN.
module gpu_rect_sequencer #(
    parameter int unsigned H_DISP  = gpu_rect_sequencer_pkg::H_DISP,
    parameter int unsigned V_DISP  = gpu_rect_sequencer_pkg::V_DISP,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_x,
    input  logic [15:0] cmd_y,
    input  logic [15:0] cmd_w,
    input  logic [15:0] cmd_h,
    input  logic [23:0] cmd_rgb,
    output logic [7:0]  gpu_addr_in,
    output logic [3:0]  gpu_size,
    output logic [31:0] gpu_data_in,
    output logic [7:0]  gpu_addr_out,
    input  logic [31:0] gpu_data_out,
    output logic        seq_busy,
    output logic        done_pulse,
    output logic        err_timeout
);
    import gpu_rect_sequencer_pkg::*;

    rectState_t  state, stateNext;
    logic [15:0] xReg, yReg, wReg, hReg, rowReg, waitCnt;
    logic [23:0] rgbReg;
    logic        abortReg, readyArm, accept, busyBit, waitTimeout, timeoutHit;
    logic [15:0] wAcc, hAcc;
    logic        emptyAcc;
    logic [16:0] yRow, rowInc;
    logic        unusedRead;

`ifdef RECT_CLIP_EN
    logic [15:0] wClip, hClip;
    logic        outside;

    gpu_rect_clip #(
        .H_DISP(H_DISP),
        .V_DISP(V_DISP)
    ) uClip (
        .x      (cmd_x),
        .y      (cmd_y),
        .w      (cmd_w),
        .h      (cmd_h),
        .wClip  (wClip),
        .hClip  (hClip),
        .outside(outside)
    );

    assign wAcc     = wClip;
    assign hAcc     = hClip;
    assign emptyAcc = outside || (wClip == 16'd0) || (hClip == 16'd0);
`else
    // Display bounds only matter when clipping is built in
    logic [31:0] unusedCfg;
    assign unusedCfg = 32'(H_DISP) ^ 32'(V_DISP);

    assign wAcc     = cmd_w;
    assign hAcc     = cmd_h;
    assign emptyAcc = (cmd_w == 16'd0) || (cmd_h == 16'd0);
`endif

    assign unusedRead   = ^gpu_data_out[31:1];
    assign busyBit      = gpu_data_out[0];
    assign cmd_ready    = readyArm && (state == IDLE);
    assign accept       = cmd_valid && cmd_ready;
    assign yRow         = {1'b0, yReg} + {1'b0, rowReg};
    assign rowInc       = {1'b0, rowReg} + 17'd1;
    assign waitTimeout  = (waitCnt == 16'(TIMEOUT));
    assign gpu_addr_out = REG_BUSY;
    assign seq_busy     = (state != IDLE);
    assign done_pulse   = (state == FIN);

    always_comb begin
        stateNext   = state;
        gpu_addr_in = 8'd0;
        gpu_size    = 4'h0;
        gpu_data_in = 32'd0;
        timeoutHit  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) stateNext = emptyAcc ? FIN : WR_X;
            end
            WR_X: begin
                gpu_addr_in = REG_X_POS;
                gpu_size    = 4'hF;
                gpu_data_in = {16'd0, xReg};
                stateNext   = WR_Y;
            end
            WR_Y: begin
                gpu_addr_in = REG_Y_POS;
                gpu_size    = 4'hF;
                gpu_data_in = {16'd0, yRow[15:0]};
                stateNext   = (rowReg == 16'd0) ? WR_PIX : WR_EN;
            end
            WR_PIX: begin
                gpu_addr_in = REG_PIXEL;
                gpu_size    = 4'hF;
                gpu_data_in = {8'd0, rgbReg};
                stateNext   = WR_LEN;
            end
            WR_LEN: begin
                gpu_addr_in = REG_LEN;
                gpu_size    = 4'hF;
                gpu_data_in = {8'd0, 24'(wReg)};
                stateNext   = WR_EN;
            end
            WR_EN: begin
                gpu_addr_in = REG_ENABLE;
                gpu_size    = 4'hF;
                gpu_data_in = 32'h1;
                stateNext   = WAIT_HI;
            end
            WAIT_HI: begin
                if ((waitCnt >= BUSY_IGNORE) && busyBit) begin
                    stateNext = WAIT_LO;
                end else if (waitTimeout) begin
                    timeoutHit = 1'b1;
                    stateNext  = WR_DIS;
                end
            end
            WAIT_LO: begin
                if (!busyBit) begin
                    stateNext = WR_DIS;
                end else if (waitTimeout) begin
                    timeoutHit = 1'b1;
                    stateNext  = WR_DIS;
                end
            end
            WR_DIS: begin
                gpu_addr_in = REG_ENABLE;
                gpu_size    = 4'hF;
                gpu_data_in = 32'h0;
                stateNext   = (abortReg || (rowInc == {1'b0, hReg})) ? FIN : WR_Y;
            end
            FIN: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // A timeout reuses WR_DIS to drop ENABLE, then abortReg forces FIN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            readyArm    <= 1'b0;
            xReg        <= 16'd0;
            yReg        <= 16'd0;
            wReg        <= 16'd0;
            hReg        <= 16'd0;
            rgbReg      <= 24'd0;
            rowReg      <= 16'd0;
            waitCnt     <= 16'd0;
            abortReg    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state    <= stateNext;
            readyArm <= 1'b1;
            if (accept) begin
                xReg        <= cmd_x;
                yReg        <= cmd_y;
                wReg        <= wAcc;
                hReg        <= hAcc;
                rgbReg      <= cmd_rgb;
                rowReg      <= 16'd0;
                abortReg    <= 1'b0;
                err_timeout <= 1'b0;
            end
            if (timeoutHit) begin
                abortReg    <= 1'b1;
                err_timeout <= 1'b1;
            end
            if ((stateNext != state) && ((stateNext == WAIT_HI) || (stateNext == WAIT_LO))) begin
                waitCnt <= 16'd0;
            end else if ((state == WAIT_HI) || (state == WAIT_LO)) begin
                waitCnt <= waitCnt + 16'd1;
            end
            if (state == WR_DIS) begin
                rowReg <= rowInc[15:0];
            end
        end
    end

endmodule

// File: tb/tb_gpu_rect_sequencer.sv
// Randomized bench for gpu_rect_sequencer with a behavioural GPU model and a
// write-sequence scoreboard computed from the command arithmetic.
module tb_gpu_rect_sequencer;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [23:0] cmd_rgb = '0;
    logic [7:0]  gpu_addr_in, gpu_addr_out;
    logic [3:0]  gpu_size;
    logic [31:0] gpu_data_in;
    logic [31:0] gpu_data_out = '0;
    logic        seq_busy, done_pulse, err_timeout;

    always #5 clk = ~clk;

    gpu_rect_sequencer #(
        .H_DISP (800),
        .V_DISP (480),
        .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_rgb     (cmd_rgb),
        .gpu_addr_in (gpu_addr_in),
        .gpu_size    (gpu_size),
        .gpu_data_in (gpu_data_in),
        .gpu_addr_out(gpu_addr_out),
        .gpu_data_out(gpu_data_out),
        .seq_busy    (seq_busy),
        .done_pulse  (done_pulse),
        .err_timeout (err_timeout)
    );

    int total = 0;
    int bad = 0;
    logic [39:0] gotQ[$];
    logic [39:0] expQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // GPU model: logs every write, raises BUSY busyDelay cycles after ENABLE=1 for busyHold cycles
    int   cycle = 0;
    int   tillBusy = -1;
    int   holdLeft = 0;
    logic busyNow = 1'b0;
    int   busyDelay = 4;
    int   busyHold = 10;
    bit   neverBusy = 1'b0;
    int   enOneCycle = 0;
    int   enOneCount = 0;
    int   errRiseCycle = -1;
    logic errPrev = 1'b0;

    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            tillBusy     = -1;
            busyNow      = 1'b0;
            errPrev      = 1'b0;
            gpu_data_out = '0;
        end else begin
            cycle++;
            if (gpu_size == 4'hF) begin
                gotQ.push_back({gpu_addr_in, gpu_data_in});
                if (gpu_addr_in == 8'd4) begin
                    if (gpu_data_in == 32'h1) begin
                        enOneCycle = cycle;
                        enOneCount++;
                        if (!neverBusy) tillBusy = busyDelay;
                    end else begin
                        tillBusy = -1;
                        busyNow  = 1'b0;
                    end
                end
            end else if (tillBusy > 0) begin
                tillBusy--;
                if (tillBusy == 0) begin
                    busyNow  = 1'b1;
                    holdLeft = busyHold;
                    tillBusy = -1;
                end
            end else if (busyNow) begin
                holdLeft--;
                if (holdLeft == 0) busyNow = 1'b0;
            end
            if (err_timeout && !errPrev) errRiseCycle = cycle;
            errPrev      = err_timeout;
            gpu_data_out = {31'd0, busyNow};
        end
    end

    function automatic void buildExpected(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] w, input logic [15:0] h,
                                          input logic [23:0] rgb);
        int ew = int'(w);
        int eh = int'(h);
`ifdef RECT_CLIP_EN
        if (x >= 800 || y >= 480) begin
            ew = 0;
            eh = 0;
        end else begin
            if (ew > 800 - int'(x)) ew = 800 - int'(x);
            if (eh > 480 - int'(y)) eh = 480 - int'(y);
        end
`endif
        if (ew == 0 || eh == 0) return;
        expQ.push_back({8'd0, 16'd0, x});
        for (int r = 0; r < eh; r++) begin
            expQ.push_back({8'd1, 16'd0, 16'(int'(y) + r)});
            if (r == 0) begin
                expQ.push_back({8'd2, 8'd0, rgb});
                expQ.push_back({8'd3, 16'd0, 16'(ew)});
            end
            expQ.push_back({8'd4, 32'h1});
            expQ.push_back({8'd4, 32'h0});
        end
    endfunction

    task automatic compareWrites(input string tag);
        checkOutput({tag, "_nwrites"}, gotQ.size(), expQ.size());
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_w%0d_addr", tag, i), 32'(gotQ[i][39:32]), 32'(expQ[i][39:32]));
            checkOutput($sformatf("%s_w%0d_data", tag, i), gotQ[i][31:0], expQ[i][31:0]);
        end
        gotQ.delete();
        expQ.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic [15:0] w,
                                 input logic [15:0] h, input logic [23:0] rgb);
        int n = 0;
        cmd_x     = x;
        cmd_y     = y;
        cmd_w     = w;
        cmd_h     = h;
        cmd_rgb   = rgb;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_in_time", 32'(n < 100), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget, output int waited);
        int n = 0;
        while (!done_pulse && n < budget) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        checkOutput({tag, "_done"}, 32'(done_pulse), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_done_one_cycle"}, 32'(done_pulse), 32'd0);
        checkOutput({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd0);
        checkOutput({tag, "_busy"}, 32'(seq_busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done_pulse), 32'd0);
        checkOutput({tag, "_err"}, 32'(err_timeout), 32'd0);
        checkOutput({tag, "_size"}, 32'(gpu_size), 32'd0);
        checkOutput({tag, "_addr_in"}, 32'(gpu_addr_in), 32'd0);
        checkOutput({tag, "_data_in"}, gpu_data_in, 32'd0);
        checkOutput({tag, "_addr_out"}, 32'(gpu_addr_out), 32'd7);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waited;
        int leak;
        int n;
        logic [15:0] rx, ry, rw, rh;
        logic [23:0] rc;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Three-row rectangle with a well-behaved GPU
        busyDelay = 4;
        busyHold  = 10;
        buildExpected(16'd10, 16'd20, 16'd5, 16'd3, 24'hFF0000);
        applyStimulus(16'd10, 16'd20, 16'd5, 16'd3, 24'hFF0000);
        checkOutput("t1_busy", 32'(seq_busy), 32'd1);
        waitDone("t1", 2000, waited);
        checkOutput("t1_err", 32'(err_timeout), 32'd0);
        compareWrites("t1");

        // Empty command finishes the cycle after accept with no writes
        applyStimulus(16'd10, 16'd20, 16'd0, 16'd3, 24'h123456);
        waitDone("t2", 50, waited);
        checkOutput("t2_latency", 32'(waited), 32'd0);
        compareWrites("t2");

        // GPU never raises BUSY
        neverBusy = 1'b1;
        expQ.push_back({8'd0, 32'd1});
        expQ.push_back({8'd1, 32'd2});
        expQ.push_back({8'd2, 32'h00ABCDEF});
        expQ.push_back({8'd3, 32'd3});
        expQ.push_back({8'd4, 32'h1});
        expQ.push_back({8'd4, 32'h0});
        applyStimulus(16'd1, 16'd2, 16'd3, 16'd4, 24'hABCDEF);
        waitDone("t3", 500, waited);
        checkOutput("t3_err", 32'(err_timeout), 32'd1);
        checkOutput("t3_err_latency", 32'(errRiseCycle - enOneCycle), 32'd102);
        compareWrites("t3");
        neverBusy = 1'b0;
        buildExpected(16'd5, 16'd6, 16'd2, 16'd1, 24'h00FF00);
        applyStimulus(16'd5, 16'd6, 16'd2, 16'd1, 24'h00FF00);
        checkOutput("t3_err_cleared", 32'(err_timeout), 32'd0);
        waitDone("t3b", 2000, waited);
        compareWrites("t3b");

        // cmd_valid held across a command: second command waits for IDLE
        buildExpected(16'd30, 16'd40, 16'd7, 16'd2, 24'h0000FF);
        buildExpected(16'd50, 16'd60, 16'd3, 16'd2, 24'h808080);
        cmd_x = 16'd30; cmd_y = 16'd40; cmd_w = 16'd7; cmd_h = 16'd2; cmd_rgb = 24'h0000FF;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_x = 16'd50; cmd_y = 16'd60; cmd_w = 16'd3; cmd_h = 16'd2; cmd_rgb = 24'h808080;
        n = 0;
        leak = 0;
        while (!done_pulse && n < 2000) begin
            if (cmd_ready) leak++;
            @(negedge clk);
            n++;
        end
        checkOutput("t4_ready_low_while_busy", 32'(leak), 32'd0);
        checkOutput("t4_done_a", 32'(done_pulse), 32'd1);
        @(negedge clk);
        checkOutput("t4_ready_after_done", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("t4_b_accepted", 32'(seq_busy), 32'd1);
        waitDone("t4b", 2000, waited);
        compareWrites("t4");

        // Clip boundary (empty when clipping is absent? no: model decides)
        buildExpected(16'd790, 16'd478, 16'd50, 16'd10, 24'h112233);
        applyStimulus(16'd790, 16'd478, 16'd50, 16'd10, 24'h112233);
        waitDone("t5", 5000, waited);
        compareWrites("t5");

        // Y wrap in 16 bits (out of range when clipping)
        buildExpected(16'd3, 16'hFFFF, 16'd2, 16'd2, 24'h445566);
        applyStimulus(16'd3, 16'hFFFF, 16'd2, 16'd2, 24'h445566);
        waitDone("t5w", 2000, waited);
        compareWrites("t5w");

        // Reset during WAIT_LO of row 1
        busyDelay = 4;
        busyHold  = 10;
        n = enOneCount;
        applyStimulus(16'd100, 16'd100, 16'd4, 16'd3, 24'h0F0F0F);
        waited = 0;
        while (!(enOneCount >= n + 2 && gpu_data_out[0]) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("t6_reached_row1", 32'(waited < 500), 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checkResetValues("t6_midreset");
        @(negedge clk);
        rstn = 1'b1;
        gotQ.delete();
        expQ.delete();
        @(negedge clk);
        buildExpected(16'd200, 16'd10, 16'd6, 16'd2, 24'h777777);
        applyStimulus(16'd200, 16'd10, 16'd6, 16'd2, 24'h777777);
        waitDone("t6", 2000, waited);
        checkOutput("t6_err", 32'(err_timeout), 32'd0);
        compareWrites("t6");

        // Randomized commands and GPU timing
        for (int k = 0; k < 25; k++) begin
            rx = 16'($urandom_range(0, 900));
            ry = 16'($urandom_range(0, 600));
            rw = 16'($urandom_range(0, 8));
            rh = 16'($urandom_range(0, 4));
            rc = 24'($urandom);
            busyDelay = int'($urandom_range(3, 8));
            busyHold  = int'($urandom_range(1, 12));
            buildExpected(rx, ry, rw, rh, rc);
            applyStimulus(rx, ry, rw, rh, rc);
            waitDone($sformatf("rnd%0d", k), 2000, waited);
            checkOutput($sformatf("rnd%0d_err", k), 32'(err_timeout), 32'd0);
            compareWrites($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
